// File: rtl/mmio_defs.sv
// Shared MMIO definitions: window geometry, register offsets, CTRL/STATUS
// bit positions and the timer FSM encoding.
package mmio_defs;

    // Every peripheral window is 32 bytes: eight 32-bit word registers.
    localparam int WIN_BYTES = 32;
    localparam int WIN_LSB   = 5;

    // Word offsets inside the window (addr[4:2]).
    typedef enum logic [2:0] {
        OFF_CTRL   = 3'd0,
        OFF_LOAD   = 3'd1,
        OFF_COUNT  = 3'd2,
        OFF_STATUS = 3'd3,
        OFF_PRESC  = 3'd4
    } reg_off_e;

    // CTRL register bits.
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AUTO_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    // STATUS register bits.
    localparam int STATUS_EXP_BIT  = 0;

    // Timer FSM; RUN mirrors CTRL.EN.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/mmio_timer_slave_tick_gen.sv
// Prescaler: counts cycles while enabled and pulses tick when the count
// reaches the programmed PRESC value, giving one tick every PRESC+1 cycles.
module tick_gen #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pc_q;
    logic [PRESC_W-1:0] pc_d;

    // Compare against PRESC, so pc never needs to wrap.
    assign tick = en && (pc_q == presc);

    // Next prescale count: restart on tick, on a sync clear, or while stopped.
    always_comb begin
        pc_d = pc_q + PRESC_W'(1);
        if (!en || clr || tick) begin
            pc_d = '0;
        end
    end

    // Prescale count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values, independent of statement order.
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mmio_timer_slave.sv
// Memory-mapped down-counter timer with prescaler, one-shot/auto-reload modes
// and a level interrupt. Answers the data-memory protocol with one-cycle
// registered read data.
module mmio_timer_slave
    import mmio_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_e         state_q, state_d;
    logic               auto_q, auto_d;
    logic               irq_en_q, irq_en_d;
    logic [31:0]        load_q, load_d;
    logic [31:0]        count_q, count_d;
    logic               exp_q, exp_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;

    reg_off_e offset;
    logic     wr_hit, wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
    logic     running, tick, tick_clr;
    logic     unused_addr_bits;

    assign sel      = (addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign offset   = reg_off_e'(addr[4:2]);
    assign running  = (state_q == ST_RUN);

    assign wr_hit    = wr && sel;
    assign wr_ctrl   = wr_hit && (offset == OFF_CTRL);
    assign wr_load   = wr_hit && (offset == OFF_LOAD);
    assign wr_count  = wr_hit && (offset == OFF_COUNT);
    assign wr_status = wr_hit && (offset == OFF_STATUS);
    assign wr_presc  = wr_hit && (offset == OFF_PRESC);

    // Byte lanes inside a word are not decoded.
    assign unused_addr_bits = ^addr[1:0];

    // Any COUNT or PRESC write restarts the prescale period.
    assign tick_clr = wr_count || wr_presc;

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .clr   (tick_clr),
        .presc (presc_q),
        .tick  (tick)
    );

    // Next register/FSM state: W1C first, then tick, then CPU writes, so a
    // same-edge expiry beats the clear and a COUNT write beats the tick.
    always_comb begin
        // NOTE: every combinational output gets a default up front; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        load_d   = load_q;
        count_d  = count_q;
        exp_d    = exp_q;
        presc_d  = presc_q;

        if (wr_status && wdata[STATUS_EXP_BIT]) begin
            exp_d = 1'b0;
        end

        if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else begin
                exp_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    count_d = 32'd0;
                    state_d = ST_IDLE;
                end
            end
        end

        if (wr_ctrl) begin
            auto_d   = wdata[CTRL_AUTO_BIT];
            irq_en_d = wdata[CTRL_IRQ_EN_BIT];
            if (!wdata[CTRL_EN_BIT]) begin
                state_d = ST_IDLE;
            end else if (!running) begin
                state_d = ST_RUN;
                count_d = load_q;
            end
        end

        if (wr_load) begin
            load_d = wdata;
        end
        if (wr_count) begin
            count_d = wdata;
        end
        if (wr_presc) begin
            presc_d = wdata[PRESC_W-1:0];
        end
    end

    // Read mux on pre-edge register values; irq follows EXP & IRQ_EN by a cycle.
    always_comb begin
        rdata_d = 32'd0;
        if (sel) begin
            case (offset)
                OFF_CTRL:   rdata_d = {29'd0, irq_en_q, auto_q, running};
                OFF_LOAD:   rdata_d = load_q;
                OFF_COUNT:  rdata_d = count_q;
                OFF_STATUS: rdata_d = {31'd0, exp_q};
                OFF_PRESC:  rdata_d = 32'(presc_q);
                default:    rdata_d = 32'd0;
            endcase
        end
        irq_d = exp_q && irq_en_q;
    end

    // All architectural state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            load_q   <= 32'd0;
            count_q  <= 32'd0;
            exp_q    <= 1'b0;
            presc_q  <= '0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            load_q   <= load_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
            presc_q  <= presc_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Self-checking bench for mmio_timer_slave: the driver issues bus cycles and
// queues the expected rdata/irq for each read; a monitor checks them the
// cycle after the read address was presented.
module tb_mmio_timer_slave;
    import mmio_defs::*;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        sel;
    logic [31:0] rdata;
    logic        irq;

    typedef struct {
        string       nm;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    logic rd_flag;
    int   checks;
    int   failures;

    mmio_timer_slave #(
        .BASE_ADDR (BASE),
        .PRESC_W   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wr    (wr),
        .wdata (wdata),
        .sel   (sel),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bus cycle, presented at the falling edge and taken at the next rise.
    task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic rd, input logic [31:0] e, input logic ie,
                       input string nm);
        exp_t x;
        @(negedge clk);
        addr    = a;
        wr      = w;
        wdata   = d;
        rd_flag = rd;
        if (rd) begin
            x.nm    = nm;
            x.rdata = e;
            x.irq   = ie;
            sb.push_back(x);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [2:0] off);
        return BASE + {27'd0, off, 2'b00};
    endfunction

    task automatic wr32(input logic [2:0] off, input logic [31:0] d);
        cyc(reg_addr(off), 1'b1, d, 1'b0, 32'd0, 1'b0, "");
    endtask

    task automatic rd32(input logic [2:0] off, input logic [31:0] e, input logic ie,
                        input string nm);
        cyc(reg_addr(off), 1'b0, 32'd0, 1'b1, e, ie, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, "");
    endtask

    // Monitor: a read taken at a rising edge is checked at the following fall.
    initial begin
        logic pend;
        exp_t x;
        forever begin
            @(posedge clk);
            pend = rd_flag;
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow: got read with no expectation");
                end else begin
                    x = sb.pop_front();
                    check({x.nm, "_rdata"}, rdata, x.rdata);
                    check({x.nm, "_irq"}, {31'd0, irq}, {31'd0, x.irq});
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        addr     = 32'd0;
        wr       = 1'b0;
        wdata    = 32'd0;
        rd_flag  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values.
        rd32(OFF_CTRL,   32'd0, 1'b0, "rst_ctrl");
        rd32(OFF_LOAD,   32'd0, 1'b0, "rst_load");
        rd32(OFF_COUNT,  32'd0, 1'b0, "rst_count");
        rd32(OFF_STATUS, 32'd0, 1'b0, "rst_status");
        rd32(OFF_PRESC,  32'd0, 1'b0, "rst_presc");

        // Decode.
        wr32(OFF_LOAD, 32'hDEAD_BEEF);
        rd32(OFF_LOAD, 32'hDEAD_BEEF, 1'b0, "load_rd");
        #1 check("sel_in_window", {31'd0, sel}, 32'd1);
        cyc(BASE + 32'h20, 1'b1, 32'h1234_5678, 1'b1, 32'd0, 1'b0, "out_of_window");
        #1 check("sel_out_window", {31'd0, sel}, 32'd0);
        cyc(BASE + 32'h07, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, "load_lowbits");
        wr32(3'd6, 32'hFFFF_FFFF);
        rd32(3'd6, 32'd0, 1'b0, "off6_rd");
        rd32(3'd5, 32'd0, 1'b0, "off5_rd");

        // One-shot: LOAD=3, PRESC=1, start at edge E0; expiry at E6.
        wr32(OFF_PRESC, 32'd1);
        wr32(OFF_LOAD, 32'd3);
        wr32(OFF_CTRL, 32'h5);
        idle(5);
        rd32(OFF_STATUS, 32'd0, 1'b0, "os_exp_e6");
        rd32(OFF_STATUS, 32'd1, 1'b1, "os_exp_e7");
        rd32(OFF_CTRL,   32'h4, 1'b1, "os_ctrl");
        rd32(OFF_COUNT,  32'd0, 1'b1, "os_count");
        cyc(reg_addr(OFF_STATUS), 1'b1, 32'd1, 1'b1, 32'd1, 1'b1, "os_w1c");
        rd32(OFF_STATUS, 32'd0, 1'b0, "os_cleared");

        // Auto-reload: LOAD=2, PRESC=0, expiry on every second edge (F2, F4...).
        wr32(OFF_PRESC, 32'd0);
        wr32(OFF_LOAD, 32'd2);
        wr32(OFF_CTRL, 32'h3);
        rd32(OFF_COUNT,  32'd2, 1'b0, "ar_f1");
        rd32(OFF_COUNT,  32'd1, 1'b0, "ar_f2");
        rd32(OFF_STATUS, 32'd1, 1'b0, "ar_f3");
        cyc(reg_addr(OFF_STATUS), 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, "ar_w1c_exp");
        cyc(reg_addr(OFF_STATUS), 1'b1, 32'd1, 1'b1, 32'd1, 1'b0, "ar_set_wins");
        rd32(OFF_STATUS, 32'd0, 1'b0, "ar_f6");
        rd32(OFF_STATUS, 32'd1, 1'b0, "ar_f7");
        rd32(OFF_COUNT,  32'd1, 1'b0, "ar_f8");
        wr32(OFF_CTRL, 32'h0);
        wr32(OFF_STATUS, 32'd1);

        // Stop/resume: LOAD=10, PRESC=3; tick every 4 cycles, COUNT=7 after G12.
        wr32(OFF_PRESC, 32'd3);
        wr32(OFF_LOAD, 32'd10);
        wr32(OFF_CTRL, 32'h1);
        idle(12);
        wr32(OFF_CTRL, 32'h0);
        rd32(OFF_COUNT, 32'd7, 1'b0, "stop_count");
        idle(3);
        rd32(OFF_COUNT, 32'd7, 1'b0, "stop_hold");
        rd32(OFF_CTRL,  32'd0, 1'b0, "stop_ctrl");
        wr32(OFF_CTRL, 32'h1);
        rd32(OFF_COUNT, 32'd10, 1'b0, "resume_reload");

        // Collision: tick edge H28 with COUNT=4; write wins, read sees 4.
        idle(26);
        cyc(reg_addr(OFF_COUNT), 1'b1, 32'd9, 1'b1, 32'd4, 1'b0, "coll_rd");
        rd32(OFF_COUNT, 32'd9, 1'b0, "coll_count");
        // Off-tick COUNT write restarts the prescaler: next tick 4 cycles later.
        wr32(OFF_COUNT, 32'd20);
        for (int i = 0; i < 4; i++) begin
            rd32(OFF_COUNT, 32'd20, 1'b0, $sformatf("pc_restart%0d", i));
        end
        rd32(OFF_COUNT, 32'd19, 1'b0, "pc_restart_tick");

        // Mid-run reset with irq high and COUNT=5.
        wr32(OFF_CTRL, 32'h7);
        wr32(OFF_COUNT, 32'd1);
        idle(5);
        rd32(OFF_LOAD, 32'd10, 1'b1, "pre_rst_load");
        wr32(OFF_COUNT, 32'd5);
        cyc(reg_addr(OFF_LOAD), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, "");
        cyc(reg_addr(OFF_LOAD), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, "");
        @(negedge clk);
        check("pre_rst_rdata", rdata, 32'd10);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_rdata", rdata, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd32(OFF_CTRL,   32'd0, 1'b0, "post_rst_ctrl");
        rd32(OFF_LOAD,   32'd0, 1'b0, "post_rst_load");
        rd32(OFF_COUNT,  32'd0, 1'b0, "post_rst_count");
        rd32(OFF_STATUS, 32'd0, 1'b0, "post_rst_status");
        rd32(OFF_PRESC,  32'd0, 1'b0, "post_rst_presc");
        idle(8);
        rd32(OFF_STATUS, 32'd0, 1'b0, "post_rst_quiet");
        idle(2);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
